pipe_stage_chain: RTL

- Parametrised instruction pipeline register chain with per-stage field breakout.
- Replaces the fixed five-stage field splitter in the CPU core. It adds owned stage registers, valid bits, stall/flush control, a retirement counter and optional read-after-write hazard detection.
- Sits between instruction fetch and the execute/writeback control logic. Downstream logic reads opcode, register selects and literal per stage from flat buses.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 24 ++
 rtl/pipe_stage_chain.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, NOP encoding and field-extract helpers for the instruction pipeline.
// The helpers work on a 64-bit carrier so parameterised callers can truncate to their own width.
package pipe_pkg;
    localparam int IW_D   = 16;
    localparam int OPW_D  = 7;
    localparam int SELW_D = 3;
    localparam int LITW_D = 15;
    localparam int XW     = 64;

    localparam logic [XW-1:0] NOP = '0;

    localparam int CSEL_LSB = 0;
    localparam int LIT_LSB  = 0;

    function automatic logic [XW-1:0] fld(input logic [XW-1:0] v, input int lsb, input int w);
        logic [XW-1:0] m;
        m = (w >= XW) ? '1 : ((XW'(1) << w) - XW'(1));
        return (v >> lsb) & m;
    endfunction

    function automatic logic [XW-1:0] op_of(input logic [XW-1:0] v, input int iw, input int opw);
        return fld(v, iw - opw, opw);
    endfunction

    function automatic logic [XW-1:0] asel_of(input logic [XW-1:0] v, input int selw);
        return fld(v, CSEL_LSB + 2 * selw, selw);
    endfunction

    function automatic logic [XW-1:0] bsel_of(input logic [XW-1:0] v, input int selw);
        return fld(v, CSEL_LSB + selw, selw);
    endfunction

    function automatic logic [XW-1:0] csel_of(input logic [XW-1:0] v, input int selw);
        return fld(v, CSEL_LSB, selw);
    endfunction

    function automatic logic [XW-1:0] lit_of(input logic [XW-1:0] v, input int litw);
        return fld(v, LIT_LSB, litw);
    endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: instruction + valid with hold and bubble controls.
// Bubble wins over hold; an invalid load is stored as NOP so bubbles decode to zero.
module pipe_stage_reg #(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          bubble,
    input  logic [IW-1:0] d_instr,
    input  logic          d_valid,
    output logic [IW-1:0] q_instr,
    output logic          q_valid
);
    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            q_instr <= '0;
            q_valid <= 1'b0;
        end else if (!hold) begin
            q_instr <= d_valid ? d_instr : '0;
            q_valid <= d_valid;
        end
    end
endmodule

// File: rtl/pipe_stage_chain.sv
// Instruction pipeline register chain with stall/flush, retirement counter and per-stage decode.
// Optional read-after-write detection is built when PIPE_RAW_DETECT_EN is defined.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int IW          = IW_D,
    parameter int DEPTH       = 5,
    parameter int OPW         = OPW_D,
    parameter int SELW        = SELW_D,
    parameter int LITW        = LITW_D,
    parameter int LIT_STAGE   = 2,
    parameter int STALL_DEPTH = 2,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNTW        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IW-1:0]         in_instr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stall,
    input  logic                  flush,
    output logic [DEPTH*IW-1:0]   stage_instr,
    output logic [DEPTH-1:0]      stage_valid,
    output logic [DEPTH*OPW-1:0]  op_flat,
    output logic [DEPTH*SELW-1:0] asel_flat,
    output logic [DEPTH*SELW-1:0] bsel_flat,
    output logic [DEPTH*SELW-1:0] csel_flat,
    output logic [LITW-1:0]       literal,
    output logic [CNTW-1:0]       retired_cnt,
    output logic                  raw_hazard
);
    logic [DEPTH-1:0][IW-1:0] s_instr;
    logic [DEPTH-1:0]         s_vld;
    logic [CNTW-1:0]          cnt;

    assign in_ready = !stall && !flush;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        localparam int K = gi + 1;
        // Stage FLUSH_DEPTH+1 takes its predecessor's flushed content, i.e. a bubble.
        localparam bit FLA = (K <= FLUSH_DEPTH);
        localparam bit FLB = (FLUSH_DEPTH > 0) && (K == FLUSH_DEPTH + 1);
        localparam bit STH = (K <= STALL_DEPTH);
        localparam bit STB = (K == STALL_DEPTH + 1);

        logic          bub, hld, dv;
        logic [IW-1:0] di;

        assign hld = STH && stall;
        assign bub = (FLA && flush) || (FLB && flush && !hld) || (STB && stall);

        if (gi == 0) begin : g_first
            assign di = in_instr;
            assign dv = in_valid && in_ready;
        end else begin : g_next
            assign di = s_instr[gi-1];
            assign dv = s_vld[gi-1];
        end

        pipe_stage_reg #(.IW(IW)) u_reg (
            .clk    (clk),
            .rst_n  (rst_n),
            .hold   (hld && !bub),
            .bubble (bub),
            .d_instr(di),
            .d_valid(dv),
            .q_instr(s_instr[gi]),
            .q_valid(s_vld[gi])
        );

        assign op_flat  [gi*OPW  +: OPW ] = OPW'(op_of(XW'(s_instr[gi]), IW, OPW));
        assign asel_flat[gi*SELW +: SELW] = SELW'(asel_of(XW'(s_instr[gi]), SELW));
        assign bsel_flat[gi*SELW +: SELW] = SELW'(bsel_of(XW'(s_instr[gi]), SELW));
        assign csel_flat[gi*SELW +: SELW] = SELW'(csel_of(XW'(s_instr[gi]), SELW));
    end

    assign stage_instr = s_instr;
    assign stage_valid = s_vld;
    assign literal     = LITW'(lit_of(XW'(s_instr[LIT_STAGE-1]), LITW));
    assign retired_cnt = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (s_vld[DEPTH-1])
            cnt <= cnt + 1'b1;
    end

`ifdef PIPE_RAW_DETECT_EN
    // Stage 2 sources against destinations of valid, non-NOP-opcode stages 3..DEPTH-1.
    always_comb begin
        raw_hazard = 1'b0;
        if (s_vld[1]) begin
            for (int j = 2; j < DEPTH - 1; j++) begin
                if (s_vld[j] && (op_flat[j*OPW +: OPW] != '0) &&
                    ((asel_flat[SELW +: SELW] == csel_flat[j*SELW +: SELW]) ||
                     (bsel_flat[SELW +: SELW] == csel_flat[j*SELW +: SELW])))
                    raw_hazard = 1'b1;
            end
        end
    end
`else
    assign raw_hazard = 1'b0;
`endif
endmodule
